// File: rtl/rgb_led_pkg.sv
// Shared definitions for the RGB LED driver: colour codes, FSM states and pin helper.
package rgb_led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    SHOW = 2'd2
  } state_t;

  // Active-high colour codes, bit order {R,G,B}
  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  // Common-anode pins: a channel is lit (low) only when its colour bit and the gate are both set
  function automatic logic [2:0] led_pins(input logic [2:0] col, input logic gate);
    return ~(col & {3{gate}});
  endfunction

endpackage

// File: rtl/rgb_led_driver_pwm_gen.sv
// PWM generator: free-running period counter, duty register reloaded only at period start.
// The wrap strobe is only brought out when RGB_LED_BLINK_EN is defined (blink phase timing).
module pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] brightness,
  output logic             pwm_on,
`ifdef RGB_LED_BLINK_EN
  output logic             wrap,
`endif
  output logic [PWM_W-1:0] duty
);

  // Period is 2**PWM_W-1 so that a full-scale duty keeps the output permanently on
  localparam logic [PWM_W-1:0] CNT_MAX = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [PWM_W-1:0] pwm_cnt;
  logic             at_max;

  assign at_max = (pwm_cnt == CNT_MAX);
  assign pwm_on = (pwm_cnt < duty);
`ifdef RGB_LED_BLINK_EN
  assign wrap   = at_max;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= '0;
    end else begin
      pwm_cnt <= at_max ? '0 : pwm_cnt + 1'b1;
      if (pwm_cnt == '0) duty <= brightness;
    end
  end

endmodule

// File: rtl/rgb_led_driver.sv
// RGB LED driver: stability filter on the classifier code, latched colour, PWM-gated LED pins.
// Optional blink gating is compiled in with RGB_LED_BLINK_EN.
module rgb_led_driver
  import rgb_led_pkg::*;
#(
  parameter int PWM_W         = 8,
  parameter int STABLE_CYCLES = 1000,
  parameter int BLINK_PERIODS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       color_n,
  input  logic             color_valid,
  input  logic [PWM_W-1:0] brightness,
`ifdef RGB_LED_BLINK_EN
  input  logic             blink,
`endif
  output logic             led_r_n,
  output logic             led_g_n,
  output logic             led_b_n,
  output logic [2:0]       color_shown,
  output logic             color_upd
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TGT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t       state, state_nxt;
  logic [2:0]   cand, cand_nxt;
  logic [CW-1:0] stab_cnt, cnt_nxt, cnt_inc;
  logic [2:0]   shown_nxt;
  logic         shown_any, any_nxt;
  logic         latch, upd_pend;
  logic [2:0]   col_new;
  logic         pwm_on, led_gate;
  logic [PWM_W-1:0] duty;

  assign col_new = ~color_n;
  assign cnt_inc = (stab_cnt == CNT_TGT) ? stab_cnt : stab_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = stab_cnt;
    shown_nxt = color_shown;
    any_nxt   = shown_any;
    latch     = 1'b0;
    if (color_valid) begin
      case (state)
        IDLE: begin
          cand_nxt  = col_new;
          cnt_nxt   = CNT_ONE;
          state_nxt = QUAL;
        end
        QUAL: begin
          // Classifier fell back to what is already displayed: drop the candidate silently
          if (shown_any && col_new == color_shown) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
          end else if (col_new == cand) begin
            cnt_nxt = cnt_inc;
          end else begin
            cand_nxt = col_new;
            cnt_nxt  = CNT_ONE;
          end
        end
        SHOW: begin
          if (col_new != color_shown) begin
            cand_nxt  = col_new;
            cnt_nxt   = CNT_ONE;
            state_nxt = QUAL;
          end
        end
        default: state_nxt = IDLE;
      endcase
      // Same-edge latch covers STABLE_CYCLES=1 as well as the final qualifying sample
      if (state_nxt == QUAL && cnt_nxt == CNT_TGT) begin
        latch     = 1'b1;
        state_nxt = SHOW;
        shown_nxt = cand_nxt;
        any_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= COL_BLACK;
      stab_cnt    <= '0;
      color_shown <= COL_BLACK;
      shown_any   <= 1'b0;
      upd_pend    <= 1'b0;
      color_upd   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      stab_cnt    <= cnt_nxt;
      color_shown <= shown_nxt;
      shown_any   <= any_nxt;
      upd_pend    <= latch;
      color_upd   <= upd_pend;
    end
  end

`ifdef RGB_LED_BLINK_EN
  localparam int PH_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BLINK_PERIODS - 1);

  logic            pwm_wrap;
  logic [PH_W-1:0] ph_cnt;
  logic            blink_ph;

  pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .brightness (brightness),
    .pwm_on     (pwm_on),
    .wrap       (pwm_wrap),
    .duty       (duty)
  );

  always_ff @(posedge clk) begin
    if (rst || !blink) begin
      ph_cnt   <= '0;
      blink_ph <= 1'b1;
    end else if (pwm_wrap) begin
      if (ph_cnt == PH_LAST) begin
        ph_cnt   <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        ph_cnt <= ph_cnt + 1'b1;
      end
    end
  end

  assign led_gate = pwm_on & (blink_ph | ~blink);
`else
  pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .brightness (brightness),
    .pwm_on     (pwm_on),
    .duty       (duty)
  );

  assign led_gate = pwm_on;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      {led_r_n, led_g_n, led_b_n} <= 3'b111;
    end else begin
      {led_r_n, led_g_n, led_b_n} <= led_pins(color_shown, led_gate);
    end
  end

  logic unused_duty;
  assign unused_duty = ^duty;

endmodule

// File: tb/tb_rgb_led_driver.sv
// Randomized scoreboard bench for rgb_led_driver (PWM_W=4, STABLE_CYCLES=4, BLINK_PERIODS=2).
module tb_rgb_led_driver;
  localparam int PWM_W  = 4;
  localparam int STABLE = 4;
  localparam int BLINKP = 2;
  localparam int P      = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] color_n = 3'b111;
  logic       color_valid = 1'b0;
  logic [3:0] brightness = 4'd0;
`ifdef RGB_LED_BLINK_EN
  logic       blink = 1'b0;
`endif
  logic       led_r_n, led_g_n, led_b_n, color_upd;
  logic [2:0] color_shown;

  int total = 0;
  int bad   = 0;
  int n_upd = 0;
  logic [2:0] exp_q[$];

  rgb_led_driver #(.PWM_W(PWM_W), .STABLE_CYCLES(STABLE), .BLINK_PERIODS(BLINKP)) dut (
    .clk         (clk),
    .rst         (rst),
    .color_n     (color_n),
    .color_valid (color_valid),
    .brightness  (brightness),
`ifdef RGB_LED_BLINK_EN
    .blink       (blink),
`endif
    .led_r_n     (led_r_n),
    .led_g_n     (led_g_n),
    .led_b_n     (led_b_n),
    .color_shown (color_shown),
    .color_upd   (color_upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: run-length view of the valid sample stream plus a period-position PWM
  logic [2:0] m_shown, m_last, m_led, s;
  bit m_any, m_pend, m_upd, gate;
  int m_run, m_pos, m_duty, m_wraps;
  bit m_ph;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_shown = 3'b000; m_last = 3'b000; m_any = 0; m_run = 0;
        m_pos = 0; m_duty = 0; m_pend = 0; m_upd = 0; m_led = 3'b111;
        m_wraps = 0; m_ph = 1;
        exp_q.delete();
      end else begin
        gate = (m_pos < m_duty);
`ifdef RGB_LED_BLINK_EN
        if (blink && !m_ph) gate = 0;
        if (!blink) begin
          m_ph = 1; m_wraps = 0;
        end else if (m_pos == P - 1) begin
          m_wraps++;
          if (m_wraps == BLINKP) begin m_wraps = 0; m_ph = !m_ph; end
        end
`endif
        m_led  = ~(m_shown & {3{gate}});
        m_upd  = m_pend;
        m_pend = 0;
        if (m_pos == 0) m_duty = brightness;
        m_pos = (m_pos + 1) % P;
        if (color_valid) begin
          s = ~color_n;
          if (m_any && s == m_shown) m_run = 0;
          else begin
            m_run  = (m_run > 0 && s == m_last) ? m_run + 1 : 1;
            m_last = s;
            if (m_run == STABLE) begin
              m_shown = s; m_any = 1; m_run = 0; m_pend = 1;
              exp_q.push_back(s);
            end
          end
        end
      end
      @(negedge clk);
      check("leds", {led_r_n, led_g_n, led_b_n}, m_led);
      check("shown", color_shown, m_shown);
      check("upd", color_upd, m_upd);
    end
  end

  // Monitor: every update pulse must match the next scoreboard entry
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (color_upd === 1'b1) begin
        n_upd++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL upd_unexpected at %0t: got pulse expected none", $time);
        end else begin
          e = exp_q.pop_front();
          check("upd_color", color_shown, e);
        end
      end
    end
  end

  task automatic step(input logic [2:0] cn, input logic v, input int n);
    color_n = cn;
    color_valid = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int snap;
    logic [2:0] code;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    brightness = 4'd15;
    step(3'b011, 1, 4);
    step(3'b011, 1, 3);
    check("red_shown", color_shown, 3'b100);
    step(3'b011, 1, 15);
    snap = n_upd;
    step(3'b101, 1, 3);
    step(3'b011, 1, 10);
    check("glitch_no_upd", n_upd, snap);
    step(3'b000, 1, 4);
    brightness = 4'd5;
    step(3'b000, 1, 40);
    step(3'b000, 0, 7);
    brightness = 4'd10;
    step(3'b000, 0, 30);
    repeat (4) begin step(3'b110, 1, 1); step(3'b110, 0, 1); end
    step(3'b110, 0, 4);
    check("toggle_latch", color_shown, 3'b001);
    step(3'b011, 1, 2);
    rst = 1; step(3'b011, 1, 1); rst = 0;
    check("rst_mid", color_shown, 3'b000);
`ifdef RGB_LED_BLINK_EN
    brightness = 4'd15;
    step(3'b000, 1, 6);
    blink = 1;
    step(3'b000, 1, 120);
    blink = 0;
    step(3'b000, 1, 10);
`endif
    code = 3'b010;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) code = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 399) == 0);
      step(code, $urandom_range(0, 3) != 0, 1);
    end
    rst = 0;
    step(3'b111, 0, 6);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
